// File: rtl/div_hilo_ctrl.sv
// Control stage around an external combinational 32-bit unsigned divider:
// converts DIV/DIVU operands to magnitudes, waits a settle budget, then writes sign-corrected HI/LO.
module div_hilo_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        op_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] div_q,
    output logic [31:0] div_m,
    input  logic [31:0] div_quo,
    input  logic [31:0] div_rem,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    // Two's complement negation, wrapping at 32 bits (-2^31 maps to itself).
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // Magnitude of an operand when it is treated as signed and negative.
    function automatic logic [31:0] mag32(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] div_q_r, div_q_s;
    logic [31:0] div_m_r, div_m_s;
    logic        neg_q_r, neg_q_s;
    logic        neg_r_r, neg_r_s;
    logic [31:0] hi_r, hi_s;
    logic [31:0] lo_r, lo_s;
    logic        dbz_r, dbz_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;

    // Next-state and next-register computation; every register holds unless a state rule updates it.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        div_q_s = div_q_r;
        div_m_s = div_m_r;
        neg_q_s = neg_q_r;
        neg_r_s = neg_r_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        dbz_s   = dbz_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    neg_q_s = op_signed & (dividend[31] ^ divisor[31]);
                    neg_r_s = op_signed & dividend[31];
                    div_q_s = mag32(op_signed, dividend);
                    div_m_s = mag32(op_signed, divisor);
                    if (divisor == 32'd0) begin
                        // Divide by zero bypasses the divider entirely.
                        state_s = ST_DONE;
                        lo_s    = 32'hFFFF_FFFF;
                        hi_s    = dividend;
                        dbz_s   = 1'b1;
                    end else begin
                        state_s = ST_SETTLE;
                        cnt_s   = CNT_LOAD;
                        dbz_s   = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == 4'd0) begin
                    lo_s    = neg_q_r ? neg32(div_quo) : div_quo;
                    hi_s    = neg_r_r ? neg32(div_rem) : div_rem;
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State and output registers; clr discards any operation in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            div_q_r <= 32'd0;
            div_m_r <= 32'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            dbz_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            div_q_r <= div_q_s;
            div_m_r <= div_m_s;
            neg_q_r <= neg_q_s;
            neg_r_r <= neg_r_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            dbz_r   <= dbz_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign div_q       = div_q_r;
    assign div_m       = div_m_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Self-checking bench for div_hilo_ctrl: directed corner cases plus random DIV/DIVU
// checked against a 64-bit arithmetic reference model.
module tb_div_hilo_ctrl;

    localparam int unsigned SETTLE = 4;

    logic        clk;
    logic        clr;
    logic        start;
    logic        op_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] div_q;
    logic [31:0] div_m;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    div_hilo_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .clr(clr), .start(start), .op_signed(op_signed),
        .dividend(dividend), .divisor(divisor), .div_q(div_q), .div_m(div_m),
        .div_quo(div_quo), .div_rem(div_rem), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    // Stand-in for the external unsigned divider.
    assign div_quo = (div_m == 32'd0) ? 32'hFFFF_FFFF : div_q / div_m;
    assign div_rem = (div_m == 32'd0) ? div_q : div_q % div_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer division in 64 bits, truncating toward zero.
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] elo, output logic [31:0] ehi,
                                  output logic [31:0] emq, output logic [31:0] emm,
                                  output logic edbz);
        longint sa, sb, q, r, ma, mb;
        sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        emq = ma[31:0];
        emm = mb[31:0];
        if (b == 32'd0) begin
            elo  = 32'hFFFF_FFFF;
            ehi  = a;
            edbz = 1'b1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            elo  = q[31:0];
            ehi  = r[31:0];
            edbz = 1'b0;
        end
    endfunction

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; op_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0 ||
            div_q !== 32'd0 || div_m !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h q=%h m=%h, expected all zero",
                     busy, done, div_by_zero, hi, lo, div_q, div_m);
        end
    endtask

    task automatic test_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] elo, ehi, emq, emm;
        logic        edbz;
        int          exp_lat, lat, bcnt;
        bit          seen, hold_ok;
        model(sgn, a, b, elo, ehi, emq, emm, edbz);
        exp_lat = edbz ? 1 : int'(SETTLE) + 1;
        @(negedge clk);
        op_signed = sgn; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        op_signed = 1'($urandom()); dividend = $urandom(); divisor = $urandom();
        lat = 0; bcnt = 0; seen = 1'b0; hold_ok = 1'b1;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            lat = i;
            if (busy) bcnt++;
            if (div_q !== emq || div_m !== emm) hold_ok = 1'b0;
            if (done) seen = 1'b1;
        end
        checks++;
        if (lat !== exp_lat || !seen) begin
            errors++;
            $display("FAIL latency %b %h/%h: got %0d expected %0d", sgn, a, b, lat, exp_lat);
        end
        checks++;
        if (bcnt !== exp_lat) begin
            errors++;
            $display("FAIL busy_cycles %b %h/%h: got %0d expected %0d", sgn, a, b, bcnt, exp_lat);
        end
        checks++;
        if (lo !== elo || hi !== ehi || div_by_zero !== edbz) begin
            errors++;
            $display("FAIL result %b %h/%h: got lo=%h hi=%h dbz=%b expected lo=%h hi=%h dbz=%b",
                     sgn, a, b, lo, hi, div_by_zero, elo, ehi, edbz);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL operands %b %h/%h: got q=%h m=%h expected q=%h m=%h held",
                     sgn, a, b, div_q, div_m, emq, emm);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || lo !== elo || hi !== ehi) begin
            errors++;
            $display("FAIL after_done %h/%h: got done=%b busy=%b lo=%h hi=%h expected 0 0 %h %h",
                     a, b, done, busy, lo, hi, elo, ehi);
        end
    endtask

    task automatic test_directed();
        test_op(1'b0, 32'd100, 32'd7);
        test_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        test_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        test_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        test_op(1'b0, 32'hFFFF_FFFF, 32'h10);
        test_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        test_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_div_by_zero();
        test_op(1'b0, 32'h1234, 32'd0);
        test_op(1'b0, 32'd100, 32'd7);
        test_op(1'b1, 32'hFFFF_FF00, 32'd0);
        test_op(1'b1, 32'hFFFF_FF00, 32'd3);
    endtask

    task automatic test_busy_ignore();
        int  lat;
        bit  seen;
        @(negedge clk);
        op_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 2; seen = 1'b0;
        for (int i = 3; i <= 40 && !seen; i++) begin
            @(negedge clk);
            lat = i;
            if (done) seen = 1'b1;
        end
        checks++;
        if (lat !== int'(SETTLE) + 1 || lo !== 32'd10 || hi !== 32'd0) begin
            errors++;
            $display("FAIL busy_ignore: got lat=%0d lo=%h hi=%h expected lat=%0d lo=%h hi=%h",
                     lat, lo, hi, SETTLE + 1, 32'd10, 32'd0);
        end
        @(negedge clk);
        test_op(1'b0, 32'd9, 32'd3);
    endtask

    task automatic test_clr_abort();
        bit seen;
        @(negedge clk);
        op_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL clr_abort: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
                     busy, done, hi, lo);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_done: got done pulse=%b expected 0", seen);
        end
        test_op(1'b0, 32'd50, 32'd5);
    endtask

    task automatic test_random();
        logic        sgn;
        logic [31:0] a, b;
        for (int n = 0; n < 30; n++) begin
            sgn = 1'($urandom());
            a   = $urandom();
            case ($urandom_range(3, 0))
                0:       b = 32'd0;
                1:       b = $urandom_range(16, 1);
                2:       b = 32'hFFFF_FFFF - $urandom_range(16, 0);
                default: b = $urandom();
            endcase
            if ($urandom_range(7, 0) == 0) a = 32'h8000_0000;
            test_op(sgn, a, b);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_busy_ignore();
        test_clr_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
